// File: rtl/matrix_scan_ctrl.sv
// Column-scan controller for a 5x7 LED matrix: frame double-buffering, group select,
// active-low column enables with a leading blanking interval, and a per-frame tick.
module matrix_scan_ctrl #(
  parameter int PRESCALE = 50000,
  parameter int BLANK    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [34:0] data_in,
  input  logic        load,
  output logic [34:0] frame_data,
  output logic [2:0]  sel,
  output logic [4:0]  col_en_n,
  output logic        blank,
  output logic        frame_tick
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(PRESCALE - 1);
  localparam logic [2:0]       SEL_LAST = 3'd4;

  typedef enum logic {
    IDLE,
    SCAN
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       sel_q, sel_d;
  logic [4:0]       col_en_n_q, col_en_n_d;
  logic             blank_q, blank_d;
  logic             frame_tick_q, frame_tick_d;
  logic [34:0]      frame_data_q, frame_data_d;
  logic [34:0]      shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic             in_blank_d;
  logic             drive_d;
  logic             frame_start_d;

  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      sel_d   = 3'd0;
    end else if (state_q == IDLE) begin
      state_d = SCAN;
      cnt_d   = '0;
      sel_d   = 3'd0;
    end else if (cnt_q == LAST_C) begin
      cnt_d = '0;
      sel_d = (sel_q == SEL_LAST) ? 3'd0 : sel_q + 3'd1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // With no blanking interval the compare would be against zero, so it is elided.
  generate
    if (BLANK == 0) begin : g_no_blank
      assign in_blank_d = 1'b0;
    end else begin : g_blank
      assign in_blank_d = (cnt_d < CNT_W'(BLANK));
    end
  endgenerate

  // Outputs are computed from the next state so that the registered outputs line up
  // with the state they describe.
  always_comb begin
    frame_start_d = (state_d == SCAN) && (cnt_d == '0) && (sel_d == 3'd0);
    drive_d       = (state_d == SCAN) && !in_blank_d;
    col_en_n_d    = drive_d ? ~(5'b00001 << sel_d) : 5'b11111;
    blank_d       = !drive_d;
    frame_tick_d  = frame_start_d;

    shadow_d     = load ? data_in : shadow_q;
    pending_d    = pending_q | load;
    frame_data_d = frame_data_q;
    if (frame_start_d) begin
      pending_d = 1'b0;
      if (load) begin
        frame_data_d = data_in;
      end else if (pending_q) begin
        frame_data_d = shadow_q;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sel_q        <= 3'd0;
      col_en_n_q   <= 5'b11111;
      blank_q      <= 1'b1;
      frame_tick_q <= 1'b0;
      frame_data_q <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      col_en_n_q   <= col_en_n_d;
      blank_q      <= blank_d;
      frame_tick_q <= frame_tick_d;
      frame_data_q <= frame_data_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
    end
  end

  assign frame_data = frame_data_q;
  assign sel        = sel_q;
  assign col_en_n   = col_en_n_q;
  assign blank      = blank_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Self-checking bench for matrix_scan_ctrl: timing table, scoreboard of loaded frames,
// and directed sequences for load/abort corner cases. A BLANK=0 instance rides along.
module tb_matrix_scan_ctrl;

  localparam int P     = 8;
  localparam int B     = 2;
  localparam int FRAME = 5 * P;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        load;
  logic [34:0] data_in;
  logic [34:0] frame_data, frame_data_b0;
  logic [2:0]  sel, sel_b0;
  logic [4:0]  col_en_n, col_en_n_b0;
  logic        blank, blank_b0;
  logic        frame_tick, frame_tick_b0;

  matrix_scan_ctrl #(.PRESCALE(P), .BLANK(B)) dut (
    .clk(clk), .reset(reset), .enable(enable), .data_in(data_in), .load(load),
    .frame_data(frame_data), .sel(sel), .col_en_n(col_en_n), .blank(blank),
    .frame_tick(frame_tick)
  );

  matrix_scan_ctrl #(.PRESCALE(4), .BLANK(0)) dut_b0 (
    .clk(clk), .reset(reset), .enable(enable), .data_in(data_in), .load(load),
    .frame_data(frame_data_b0), .sel(sel_b0), .col_en_n(col_en_n_b0), .blank(blank_b0),
    .frame_tick(frame_tick_b0)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         pos;
    logic [2:0] sel;
    logic [4:0] col;
    logic       blank;
    logic       tick;
  } vec_t;

  int          n_vec  = 0;
  int          n_fail = 0;
  int          pos    = -1;   // cycle within frame; -1 while idle
  logic [34:0] fd_exp = '0;
  logic [34:0] sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus followed by checks against the slot/frame arithmetic.
  task automatic cyc(input logic en, input logic ld, input logic [34:0] d);
    logic [2:0] es;
    logic [4:0] ec;
    logic       eb, et;
    int         cnt;
    enable  = en;
    load    = ld;
    data_in = d;
    if (ld) sb.push_back(d);
    @(posedge clk);
    #1;
    if (!en)          pos = -1;
    else if (pos < 0) pos = 0;
    else              pos = (pos + 1) % FRAME;
    if (pos < 0) begin
      es = 3'd0; ec = 5'h1f; eb = 1'b1; et = 1'b0;
    end else begin
      es  = 3'(pos / P);
      cnt = pos % P;
      eb  = (cnt < B);
      ec  = eb ? 5'h1f : ~(5'b00001 << es);
      et  = (pos == 0);
    end
    if (et && sb.size() > 0) begin
      fd_exp = sb[$];
      sb.delete();
    end
    check("sel", sel, es);
    check("col_en_n", col_en_n, ec);
    check("blank", blank, eb);
    check("frame_tick", frame_tick, et);
    check("frame_data", frame_data, fd_exp);
    check("blank0_blank", blank_b0, (pos < 0));
    load = 1'b0;
  endtask

  task automatic run_to(input int target);
    int guard = 0;
    while (pos != target && guard < 200) begin
      cyc(1'b1, 1'b0, '0);
      guard++;
    end
    check("run_to_pos", pos, target);
  endtask

  task automatic do_reset(input int n);
    reset   = 1'b1;
    enable  = 1'b1;
    load    = 1'b1;
    data_in = '1;
    repeat (n) @(posedge clk);
    #1;
    check("rst_sel", sel, 3'd0);
    check("rst_col", col_en_n, 5'h1f);
    check("rst_blank", blank, 1'b1);
    check("rst_tick", frame_tick, 1'b0);
    check("rst_fd", frame_data, 35'h0);
    reset  = 1'b0;
    load   = 1'b0;
    pos    = -1;
    fd_exp = '0;
    sb.delete();
  endtask

  vec_t vt[13];

  initial begin
    vt[0]  = '{0,  3'd0, 5'h1f, 1'b1, 1'b1};
    vt[1]  = '{1,  3'd0, 5'h1f, 1'b1, 1'b0};
    vt[2]  = '{2,  3'd0, 5'h1e, 1'b0, 1'b0};
    vt[3]  = '{7,  3'd0, 5'h1e, 1'b0, 1'b0};
    vt[4]  = '{8,  3'd1, 5'h1f, 1'b1, 1'b0};
    vt[5]  = '{10, 3'd1, 5'h1d, 1'b0, 1'b0};
    vt[6]  = '{18, 3'd2, 5'h1b, 1'b0, 1'b0};
    vt[7]  = '{26, 3'd3, 5'h17, 1'b0, 1'b0};
    vt[8]  = '{31, 3'd3, 5'h17, 1'b0, 1'b0};
    vt[9]  = '{34, 3'd4, 5'h0f, 1'b0, 1'b0};
    vt[10] = '{39, 3'd4, 5'h0f, 1'b0, 1'b0};
    vt[11] = '{0,  3'd0, 5'h1f, 1'b1, 1'b1};
    vt[12] = '{16, 3'd2, 5'h1f, 1'b1, 1'b0};

    reset = 1'b1; enable = 1'b0; load = 1'b0; data_in = '0;
    @(negedge clk);

    // Reset dominates enable/load; first frame afterwards shows zero.
    do_reset(3);
    cyc(1'b1, 1'b0, '0);
    check("first_frame_fd", frame_data, 35'h0);

    // Scan timing table.
    for (int i = 0; i < 13; i++) begin
      run_to(vt[i].pos);
      check($sformatf("tbl%0d_sel", i), sel, vt[i].sel);
      check($sformatf("tbl%0d_col", i), col_en_n, vt[i].col);
      check($sformatf("tbl%0d_blank", i), blank, vt[i].blank);
      check($sformatf("tbl%0d_tick", i), frame_tick, vt[i].tick);
    end

    // Mid-frame load in slot 2 is deferred to the next frame start.
    cyc(1'b1, 1'b1, 35'h1_2345_6789);
    run_to(39);
    check("defer_hold", frame_data, 35'h0);
    run_to(0);
    check("defer_commit", frame_data, 35'h1_2345_6789);

    // Last load in a frame wins; pending then clear.
    run_to(4);
    cyc(1'b1, 1'b1, 35'h0_0000_007F);
    run_to(20);
    cyc(1'b1, 1'b1, 35'h7_F000_0000);
    run_to(0);
    check("last_wins", frame_data, 35'h7_F000_0000);
    run_to(39);
    run_to(0);
    check("no_recommit", frame_data, 35'h7_F000_0000);

    // Load on the edge entering the frame start bypasses the shadow.
    run_to(39);
    cyc(1'b1, 1'b1, 35'h5_5555_5555);
    check("bypass_tick", frame_tick, 1'b1);
    check("bypass_fd", frame_data, 35'h5_5555_5555);
    run_to(39);
    run_to(0);
    check("bypass_no_pending", frame_data, 35'h5_5555_5555);

    // Abort at slot 3 cnt 5 with pending data; re-enable commits it.
    run_to(25);
    cyc(1'b1, 1'b1, 35'h0_1234_5678);
    run_to(29);
    cyc(1'b0, 1'b0, '0);
    check("abort_sel", sel, 3'd0);
    check("abort_col", col_en_n, 5'h1f);
    check("abort_blank", blank, 1'b1);
    check("abort_fd", frame_data, 35'h5_5555_5555);
    cyc(1'b0, 1'b0, '0);
    cyc(1'b1, 1'b0, '0);
    check("reen_tick", frame_tick, 1'b1);
    check("reen_sel", sel, 3'd0);
    check("reen_fd", frame_data, 35'h0_1234_5678);

    // Load while idle is committed at the first frame start after enable.
    run_to(10);
    cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b1, 35'h2_AAAA_AAAA);
    cyc(1'b0, 1'b0, '0);
    check("idle_load_hold", frame_data, 35'h0_1234_5678);
    cyc(1'b1, 1'b0, '0);
    check("idle_load_commit", frame_data, 35'h2_AAAA_AAAA);

    // Reset discards pending data.
    run_to(12);
    cyc(1'b1, 1'b1, 35'h3_0000_0001);
    do_reset(1);
    cyc(1'b1, 1'b0, '0);
    check("rst_clears_pending", frame_data, 35'h0);
    run_to(39);
    run_to(0);
    check("rst_pending_gone", frame_data, 35'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
